fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined CPU. It keeps a shift-register scoreboard of destination tags for in-flight instructions and compares the ID-stage source registers against it. It outputs registered EX-stage operand-forwarding selects for any pipeline depth, raises load-use and multi-cycle-unit (MDU) interlocks, and tracks MDU busy time with an internal counter. It sits between the ID/EX pipeline register and the EX operand muxes, and drives the PC/IFID write-enable.

---
 rtl/fwd_hazard_ctrl_if.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 93 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / EX-select response bundle between decode and fwd_hazard_ctrl.
// master = decode side, slave = the controller.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned RW    = 5,
  parameter int unsigned DEPTH = 3
) ();
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [RW-1:0] id_rd;
  logic          id_rfwr;
  logic          id_load;
  logic          id_mdu;
  logic          id_mdu_rd;
  logic          flush;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          stall;
  logic          mdu_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_rfwr, id_load,
           id_mdu, id_mdu_rd, flush,
    input  fwd_a, fwd_b, stall, mdu_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_rfwr, id_load,
           id_mdu, id_mdu_rd, flush,
    output fwd_a, fwd_b, stall, mdu_busy
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller: destination-tag scoreboard, registered EX forward
// selects, load-use and MDU interlocks.
module fwd_hazard_ctrl #(
  parameter int unsigned RW      = 5,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fwd_hazard_ctrl_if.slave   bus
);
  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  // Entry 0 is the instruction in EX; entry k sits at forwarding position k+1.
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][RW-1:0] r_rd;
  logic                     r_ld0;
  logic [SW-1:0]            r_fwd_a;
  logic [SW-1:0]            r_fwd_b;
  logic [CW-1:0]            r_cnt;
  logic                     r_busy;

  logic [DEPTH-1:0] w_match_a;
  logic [DEPTH-1:0] w_match_b;
  logic [SW-1:0]    w_fwd_a;
  logic [SW-1:0]    w_fwd_b;
  logic             w_load_use;
  logic             w_mdu_haz;
  logic             w_stall;
  logic             w_issue;
  logic             w_wr0;
  logic [CW-1:0]    w_cnt_d;

  always_comb begin
    w_match_a = '0;
    w_match_b = '0;
    w_fwd_a   = '0;
    w_fwd_b   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match_a[k] = bus.id_rs_used & r_vld[k] & (r_rd[k] == bus.id_rs);
      w_match_b[k] = bus.id_rt_used & r_vld[k] & (r_rd[k] == bus.id_rt);
    end
    // Walk oldest to youngest so the youngest producer overrides.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_match_a[k]) w_fwd_a = SW'(k + 1);
      if (w_match_b[k]) w_fwd_b = SW'(k + 1);
    end
  end

  always_comb begin
    w_load_use = (w_match_a[0] | w_match_b[0]) & r_ld0;
    w_mdu_haz  = (bus.id_mdu | bus.id_mdu_rd) & (r_cnt != '0);
    w_stall    = bus.id_valid & ~bus.flush & (w_load_use | w_mdu_haz);
    w_issue    = bus.id_valid & ~w_stall & ~bus.flush;
    w_wr0      = w_issue & bus.id_rfwr & (bus.id_rd != '0);
  end

  // A fresh MDU issue reloads the counter even on the cycle it would reach zero.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_issue & bus.id_mdu) begin
      w_cnt_d = CW'(MDU_LAT);
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld   <= '0;
      r_rd    <= '0;
      r_ld0   <= 1'b0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_vld   <= {r_vld[DEPTH-2:0], w_wr0};
      r_rd    <= {r_rd[DEPTH-2:0], bus.id_rd};
      r_ld0   <= w_issue & bus.id_load;
      r_fwd_a <= w_issue ? w_fwd_a : '0;
      r_fwd_b <= w_issue ? w_fwd_b : '0;
      r_cnt   <= w_cnt_d;
      r_busy  <= (w_cnt_d != '0);
    end
  end

  assign bus.fwd_a    = r_fwd_a;
  assign bus.fwd_b    = r_fwd_b;
  assign bus.stall    = w_stall;
  assign bus.mdu_busy = r_busy;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic, checked against a
// history-queue reference model of the forwarding and interlock rules.
module tb_fwd_hazard_ctrl;
  localparam int unsigned RW      = 5;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned MDU_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.RW(RW), .DEPTH(DEPTH)) bus ();

  fwd_hazard_ctrl #(.RW(RW), .DEPTH(DEPTH), .MDU_LAT(MDU_LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: one record per EX cycle (-1 = nothing forwardable), newest at the back.
  int q_dest[$];
  bit q_ld[$];
  int cyc_n    = 0;
  int mdu_done = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int model_fwd(input int src, input bit used);
    if (!used) return 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (j < q_dest.size() && q_dest[q_dest.size() - 1 - j] == src) return j + 1;
    end
    return 0;
  endfunction

  function automatic bit model_load_use(input int src, input bit used);
    if (!used || q_dest.size() == 0) return 1'b0;
    return q_dest[q_dest.size() - 1] == src && q_ld[q_ld.size() - 1];
  endfunction

  task automatic model_reset();
    q_dest.delete();
    q_ld.delete();
    mdu_done = 0;
  endtask

  // Drive one ID cycle starting just after a rising edge; return the observed stall.
  task automatic cyc(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                     input int rd, input bit wr, input bit ld, input bit md, input bit mr,
                     input bit fl, output bit st);
    int  efa, efb;
    bit  lu, busy, est, iss;
    bus.id_valid   = v;
    bus.id_rs      = RW'(rs);
    bus.id_rt      = RW'(rt);
    bus.id_rs_used = rsu;
    bus.id_rt_used = rtu;
    bus.id_rd      = RW'(rd);
    bus.id_rfwr    = wr;
    bus.id_load    = ld;
    bus.id_mdu     = md;
    bus.id_mdu_rd  = mr;
    bus.flush      = fl;
    #1;
    efa  = model_fwd(rs, rsu);
    efb  = model_fwd(rt, rtu);
    lu   = model_load_use(rs, rsu) || model_load_use(rt, rtu);
    busy = cyc_n < mdu_done;
    est  = v && !fl && (lu || ((md || mr) && busy));
    iss  = v && !est && !fl;
    st   = bus.stall;
    check("stall", int'(bus.stall), int'(est));
    @(posedge clk);
    #1;
    q_dest.push_back((iss && wr && rd != 0) ? rd : -1);
    q_ld.push_back(iss && ld);
    if (q_dest.size() > DEPTH) begin
      void'(q_dest.pop_front());
      void'(q_ld.pop_front());
    end
    if (iss && md) mdu_done = cyc_n + 1 + MDU_LAT;
    cyc_n++;
    check("fwd_a", int'(bus.fwd_a), iss ? efa : 0);
    check("fwd_b", int'(bus.fwd_b), iss ? efb : 0);
    check("mdu_busy", int'(bus.mdu_busy), int'(cyc_n < mdu_done));
  endtask

  task automatic nop();
    bit st;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  task automatic alu(input int rs, input int rt, input int rd, output bit st);
    cyc(1, rs, rt, 1, 1, rd, 1, 0, 0, 0, 0, st);
  endtask

  initial begin
    bit st;
    int nst, nbusy;
    bit busy_seen;
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0;
    bus.id_rt_used = 0; bus.id_rd = '0; bus.id_rfwr = 0; bus.id_load = 0;
    bus.id_mdu = 0; bus.id_mdu_rd = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fwd_a", int'(bus.fwd_a), 0);
    check("rst_fwd_b", int'(bus.fwd_b), 0);
    check("rst_busy", int'(bus.mdu_busy), 0);
    rst = 1'b0;
    model_reset();

    // add r3 ; sub r4,r3,r3
    alu(1, 2, 3, st);
    alu(3, 3, 4, st);
    check("b2b_stall", int'(st), 0);
    check("b2b_fwd_a", int'(bus.fwd_a), 1);
    check("b2b_fwd_b", int'(bus.fwd_b), 1);

    // lw r5 ; add r6,r5,r0 -> one bubble then select WB
    cyc(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, st);
    alu(5, 0, 6, st);
    check("lu_stall", int'(st), 1);
    check("lu_bubble_a", int'(bus.fwd_a), 0);
    alu(5, 0, 6, st);
    check("lu_release", int'(st), 0);
    check("lu_fwd_a", int'(bus.fwd_a), 2);
    check("lu_fwd_b", int'(bus.fwd_b), 0);

    // Producer r7 with two and three unrelated instructions in between
    alu(1, 1, 7, st); alu(1, 1, 10, st); alu(1, 1, 11, st);
    alu(7, 1, 12, st);
    check("far_fwd", int'(bus.fwd_a), 3);
    alu(1, 1, 7, st); alu(1, 1, 10, st); alu(1, 1, 11, st); alu(1, 1, 14, st);
    alu(7, 1, 12, st);
    check("rf_fwd", int'(bus.fwd_a), 0);

    // Two r8 producers: youngest wins; r0 and unused rt never forward
    alu(1, 1, 8, st); alu(1, 1, 8, st);
    cyc(1, 8, 8, 1, 0, 9, 1, 0, 0, 0, 0, st);
    check("young_fwd_a", int'(bus.fwd_a), 1);
    check("rt_unused_fwd_b", int'(bus.fwd_b), 0);
    alu(1, 1, 0, st);
    alu(0, 0, 15, st);
    check("r0_fwd_a", int'(bus.fwd_a), 0);

    // mult ; mflo
    cyc(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, st);
    nst = 0;
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      busy_seen = bus.mdu_busy;
      cyc(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, st);
      if (!st) break;
      nst++;
      if (busy_seen) nbusy++;
    end
    check("mdu_stalls", nst, MDU_LAT);
    check("mdu_busy_cycles", nbusy, MDU_LAT);
    check("mdu_idle", int'(bus.mdu_busy), 0);

    // lw r9 ; flushed dependent writing r12 ; consumer of r9 and r12
    cyc(1, 1, 0, 1, 0, 9, 1, 1, 0, 0, 0, st);
    cyc(1, 9, 0, 1, 0, 12, 1, 0, 0, 0, 1, st);
    check("flush_stall", int'(st), 0);
    alu(9, 12, 13, st);
    check("flush_fwd_a", int'(bus.fwd_a), 2);
    check("flush_fwd_b", int'(bus.fwd_b), 0);

    // Async reset with the MDU counter at 2, then no stale forwarding
    cyc(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, st);
    alu(1, 1, 13, st);
    nop();
    check("pre_rst_busy", int'(bus.mdu_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(bus.mdu_busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    alu(13, 13, 14, st);
    check("post_rst_fwd", int'(bus.fwd_a), 0);
    cyc(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, st);
    check("post_rst_mdu", int'(st), 0);

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
          $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
